sdram_responder: RTL and testbench
==================================

// Module: sdram_responder
// PURPOSE
//  Synthesizable SDR SDRAM device-side responder: the far end of the sdram_controller pin interface.
//  Decodes CKE/CS/RAS/CAS/WE commands, tracks per-bank row state, stores write data in a small
//  truncated array and returns read data after the programmed CAS latency. Flags protocol violations.
//  Used in simulation/FPGA loopback benches in place of the real IS42S16160G part.
// PARAMETERS
//  MEM_ROW_BITS  4     row LSBs kept in array index
//  MEM_COL_BITS  4     column LSBs kept in array index (index = {bank, row LSBs, col LSBs})
//  TRCD          2     min cycles from ACT to READ/WRITE on same bank
//  REF_MAX       1024  max cycles between REFRESH commands once mode_valid=1
// PORTS
//  clk             in     1   clock; all commands sampled on posedge
//  rst_n           in     1   asynchronous active-low reset
//  clock_enable    in     1   CKE; 0 = command ignored (NOP)
//  cs_n            in     1   chip select; 1 = command ignored (NOP)
//  ras_n,cas_n,we_n in    1   command bits
//  addr            in     13  row (ACT), {A10,col} (READ/WRITE), mode (MRS), A10=all (PRE)
//  bank_addr       in     2   bank select
//  data            inout  16  driven only in read-data cycle, else 16'bz
//  data_mask_low   in     1   1 = do not write data[7:0]
//  data_mask_high  in     1   1 = do not write data[15:8]
//  mode_valid      out    1   MRS accepted since reset
//  mode_cl         out    3   programmed CAS latency (2 or 3)
//  bank_open       out    4   per-bank row-active flags
//  ref_cnt         out    16  REFRESH commands accepted, saturating at 16'hFFFF
//  proto_err       out    1   sticky violation flag
//  err_code        out    3   code of FIRST violation; held until reset
// BEHAVIOUR
//  Reset (async): data=Z, read pipeline cleared, mode_valid=0, mode_cl=0, bank_open=0, ref_cnt=0,
//   proto_err=0, err_code=0, refresh watchdog=0. Array contents not reset (read of unwritten = undefined).
//  Decode {ras_n,cas_n,we_n} when CKE=1&cs_n=0: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE,
//   001 REF, 000 MRS.
//  MRS: legal only with all banks idle; A2:0 must be 000 (BL1), A6:4 in {010,011}; sets mode_cl,
//   mode_valid=1. Otherwise error, mode unchanged.
//  ACT: bank must be idle; latches row, sets bank_open[b], restarts that bank's tRCD counter.
//  WRITE: bank open and >=TRCD cycles since ACT; data sampled at SAME edge as command; masks per byte.
//  READ: same legality; read at edge T drives array word on data during cycle between edges
//   T+CL-1 and T+CL (exactly one cycle). CL-deep pipeline; back-to-back READs each return in order.
//  A10=1 on READ/WRITE: bank closed after the command edge. PRE: closes bank b, or all if A10=1.
//  REF: all banks must be idle; ref_cnt++ ; clears watchdog. Watchdog counts while mode_valid=1;
//   reaching REF_MAX+1 without REF -> error (once).
//  Illegal command is otherwise ignored (no array write, no data drive, bank state unchanged).
//  err_code: 1 ACT-open-bank, 2 RD/WR-idle-bank, 3 tRCD, 4 cmd-before-MRS (ACT/RD/WR),
//   5 REF/MRS-with-open-bank, 6 bad-MRS, 7 refresh-timeout. proto_err/err_code update one edge
//   after offending command; later errors do not overwrite code. WRITE while read data pending
//   in the drive cycle -> code 2 precedence not applied; flagged as code 2? No: bus contention
//   is not checked (controller owns turnaround).
//  Simultaneous error sources on one edge: lowest code wins.
//  Reset mid-read: data returns to Z asynchronously, pending reads discarded.
// TESTING
//  T1 reset, MRS addr=13'h0230 -> mode_valid=1, mode_cl=3, proto_err=0
//  T2 ACT b1 row 5; 3 clk later WRITE col 3 A10=1 data 16'hA5C3; ACT b1; READ col 3 at edge T
//     -> data=16'hA5C3 only in cycle T+2..T+3, bank_open[1]=0 after each CAS
//  T3 write 16'h1234, then 16'hFFFF with data_mask_high=1 -> read returns 16'h12FF
//  T4 READ to idle bank 2 -> proto_err=1, err_code=2 next edge, data stays Z
//  T5 ACT then READ 1 cycle later -> err_code=3; fresh reset, 3 REFs idle -> ref_cnt=3;
//     no REF for REF_MAX+1 cycles -> err_code=7
//  T6 rst_n low during read-data cycle -> data Z immediately, all outputs at reset values

Source files
------------

// File: rtl/sdram_responder.sv
// ---------------------------------------------------------------------------
// sdram_responder
//   Device-side model of an SDR SDRAM part for simulation and FPGA loopback
//   benches. It sits on the controller's pin interface, decodes commands,
//   tracks per-bank row state, stores write data in a small truncated array
//   and returns read data after the programmed CAS latency. Protocol
//   violations raise a sticky flag that carries the code of the first one.
//
// Ports
//   clk             clock; every command is sampled on the rising edge
//   rst_n           asynchronous active-low reset
//   clock_enable    CKE; low means the command is treated as NOP
//   cs_n            chip select; high means the command is treated as NOP
//   ras_n/cas_n/we_n command bits
//   addr[12:0]      row (ACT), {A10, column} (READ/WRITE), mode (MRS),
//                   A10 = all banks (PRE)
//   bank_addr[1:0]  bank select
//   data[15:0]      bidirectional data; driven only in the read-data cycle
//   data_mask_low   1 = keep the stored data[7:0] on a write
//   data_mask_high  1 = keep the stored data[15:8] on a write
//   mode_valid      a mode register set has been accepted since reset
//   mode_cl[2:0]    programmed CAS latency (2 or 3)
//   bank_open[3:0]  per-bank row-active flags
//   ref_cnt[15:0]   accepted REFRESH commands, saturating
//   proto_err       sticky protocol violation flag
//   err_code[2:0]   code of the first violation
//                   1 ACT to open bank       2 READ/WRITE to idle bank
//                   3 tRCD not met           4 ACT/READ/WRITE before MRS
//                   5 REF/MRS with open bank 6 bad MRS value
//                   7 refresh timeout
// ---------------------------------------------------------------------------
module sdram_responder #(
  parameter int MEM_ROW_BITS = 4,
  parameter int MEM_COL_BITS = 4,
  parameter int TRCD         = 2,
  parameter int REF_MAX      = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clock_enable,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [12:0] addr,
  input  logic [1:0]  bank_addr,
  inout  wire  [15:0] data,
  input  logic        data_mask_low,
  input  logic        data_mask_high,
  output logic        mode_valid,
  output logic [2:0]  mode_cl,
  output logic [3:0]  bank_open,
  output logic [15:0] ref_cnt,
  output logic        proto_err,
  output logic [2:0]  err_code
);

  localparam int IDX_BITS = 2 + MEM_ROW_BITS + MEM_COL_BITS;
  localparam int DEPTH    = 1 << IDX_BITS;
  // tRCD counter saturates at TRCD; watchdog saturates at REF_MAX+1
  localparam int TW       = $clog2(TRCD + 2);
  localparam int WW       = $clog2(REF_MAX + 2);

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_READ,
    CMD_WRITE,
    CMD_PRE,
    CMD_REF,
    CMD_MRS
  } cmd_t;

  cmd_t                               cmd;
  logic [2:0]                         cmd_err;
  logic                               cmd_ok;
  logic                               timeout;
  logic [2:0]                         err_now;
  logic                               mrs_fields_ok;
  logic                               rcd_ok;
  logic                               sel_open;
  logic [IDX_BITS-1:0]                idx;
  logic [15:0]                        rd_word;

  logic [3:0][MEM_ROW_BITS-1:0]       row_q;
  logic [3:0][TW-1:0]                 rcd_cnt;
  logic [WW-1:0]                      wd_cnt;
  logic [2:0]                         err_q;

  // read pipeline: stage 1 -> stage 0 -> drive register
  logic                               p1_valid;
  logic [15:0]                        p1_data;
  logic                               p0_valid;
  logic [15:0]                        p0_data;
  logic                               drv_valid;
  logic [15:0]                        drv_data;

  logic [15:0]                        mem [DEPTH];

  // Only some address bits are meaningful for any one command; this keeps
  // the rest visibly consumed.
  logic                               unused_addr;
  assign unused_addr = ^addr;

  assign data = drv_valid ? drv_data : 16'bz;

  // Command decode; deselect, CKE low and burst-terminate all act as NOP.
  always_comb begin
    cmd = CMD_NOP;
    if (clock_enable && !cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_READ;
        3'b100:  cmd = CMD_WRITE;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_MRS;
        default: cmd = CMD_NOP;
      endcase
    end
  end

  assign sel_open      = bank_open[bank_addr];
  assign rcd_ok        = rcd_cnt[bank_addr] >= TW'(TRCD);
  assign mrs_fields_ok = (addr[2:0] == 3'b000) &&
                         ((addr[6:4] == 3'b010) || (addr[6:4] == 3'b011));
  assign idx           = {bank_addr, row_q[bank_addr], addr[MEM_COL_BITS-1:0]};
  assign rd_word       = mem[idx];

  // Legality check; checks are ordered by code so the lowest code wins
  // when one command breaks several rules.
  always_comb begin
    cmd_err = 3'd0;
    case (cmd)
      CMD_ACT: begin
        if (sel_open)         cmd_err = 3'd1;
        else if (!mode_valid) cmd_err = 3'd4;
      end
      CMD_READ, CMD_WRITE: begin
        if (!sel_open)        cmd_err = 3'd2;
        else if (!rcd_ok)     cmd_err = 3'd3;
        else if (!mode_valid) cmd_err = 3'd4;
      end
      CMD_REF: begin
        if (|bank_open)       cmd_err = 3'd5;
      end
      CMD_MRS: begin
        if (|bank_open)          cmd_err = 3'd5;
        else if (!mrs_fields_ok) cmd_err = 3'd6;
      end
      default: cmd_err = 3'd0;
    endcase
  end

  assign cmd_ok  = (cmd_err == 3'd0);

  // The watchdog fires on the edge it would reach REF_MAX+1; a legal REF on
  // that same edge rescues it. Saturation keeps it from firing twice.
  assign timeout = mode_valid && (wd_cnt == WW'(REF_MAX)) &&
                   !((cmd == CMD_REF) && cmd_ok);
  assign err_now = (cmd_err != 3'd0) ? cmd_err : (timeout ? 3'd7 : 3'd0);

  // Storage array is deliberately not reset; unwritten words read undefined.
  always_ff @(posedge clk) begin
    if ((cmd == CMD_WRITE) && cmd_ok) begin
      if (!data_mask_low)  mem[idx][7:0]  <= data[7:0];
      if (!data_mask_high) mem[idx][15:8] <= data[15:8];
    end
  end

  // Bank state, mode register, refresh count and watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_valid <= 1'b0;
      mode_cl    <= 3'd0;
      bank_open  <= 4'd0;
      row_q      <= '0;
      rcd_cnt    <= '0;
      ref_cnt    <= 16'd0;
      wd_cnt     <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (rcd_cnt[b] != TW'(TRCD)) rcd_cnt[b] <= rcd_cnt[b] + TW'(1);
      end

      if ((cmd == CMD_REF) && cmd_ok)
        wd_cnt <= '0;
      else if (mode_valid && (wd_cnt != WW'(REF_MAX + 1)))
        wd_cnt <= wd_cnt + WW'(1);

      if (cmd_ok) begin
        case (cmd)
          CMD_ACT: begin
            bank_open[bank_addr] <= 1'b1;
            row_q[bank_addr]     <= addr[MEM_ROW_BITS-1:0];
            // counter is 1 on the edge after ACT, so ACT+TRCD is legal
            rcd_cnt[bank_addr]   <= TW'(1);
          end
          CMD_READ, CMD_WRITE: begin
            if (addr[10]) bank_open[bank_addr] <= 1'b0;
          end
          CMD_PRE: begin
            if (addr[10]) bank_open <= 4'd0;
            else          bank_open[bank_addr] <= 1'b0;
          end
          CMD_REF: begin
            if (ref_cnt != 16'hFFFF) ref_cnt <= ref_cnt + 16'd1;
          end
          CMD_MRS: begin
            mode_cl    <= addr[6:4];
            mode_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Violations are staged one edge before reaching the sticky outputs;
  // only the first one is ever recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 3'd0;
      proto_err <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      err_q <= err_now;
      if (!proto_err && (err_q != 3'd0)) begin
        proto_err <= 1'b1;
        err_code  <= err_q;
      end
    end
  end

  // Read return pipeline. A READ at edge T enters the stage that reaches
  // the drive register at edge T+CL-1, so the word is on the bus for the
  // single cycle up to edge T+CL. Back-to-back reads follow each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid  <= 1'b0;
      p1_data   <= 16'd0;
      p0_valid  <= 1'b0;
      p0_data   <= 16'd0;
      drv_valid <= 1'b0;
      drv_data  <= 16'd0;
    end else begin
      drv_valid <= p0_valid;
      drv_data  <= p0_data;
      p0_valid  <= p1_valid;
      p0_data   <= p1_data;
      p1_valid  <= 1'b0;
      if ((cmd == CMD_READ) && cmd_ok) begin
        if (mode_cl == 3'd3) begin
          p1_valid <= 1'b1;
          p1_data  <= rd_word;
        end else begin
          p0_valid <= 1'b1;
          p0_data  <= rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// ---------------------------------------------------------------------------
// tb_sdram_responder
//   Self-checking bench for sdram_responder. A table of command vectors with
//   hand-computed expectations covers the main read/write/mask/error flow;
//   short hand-written sequences cover tRCD, MRS/REF rules, CL=2 timing,
//   the refresh watchdog and reset in the middle of a read-data cycle.
// ---------------------------------------------------------------------------
module tb_sdram_responder;

  typedef enum logic [2:0] {C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_MRS} tb_cmd_e;

  typedef struct {
    tb_cmd_e     cmd;
    logic [1:0]  bank;
    logic [12:0] addr;
    logic        drive;
    logic [15:0] wdata;
    logic        mask_low;
    logic        mask_high;
    logic [3:0]  exp_bank_open;
    logic        exp_err;
    logic [2:0]  exp_code;
    logic [1:0]  data_mode;   // 0 ignore, 1 must equal exp_data, 2 must not equal
    logic [15:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clock_enable = 1'b0;
  logic        cs_n = 1'b1;
  logic        ras_n = 1'b1;
  logic        cas_n = 1'b1;
  logic        we_n = 1'b1;
  logic [12:0] addr = 13'd0;
  logic [1:0]  bank_addr = 2'd0;
  logic        data_mask_low = 1'b0;
  logic        data_mask_high = 1'b0;
  logic        tb_drive = 1'b0;
  logic [15:0] tb_data = 16'd0;
  wire  [15:0] data;
  logic        mode_valid;
  logic [2:0]  mode_cl;
  logic [3:0]  bank_open;
  logic [15:0] ref_cnt;
  logic        proto_err;
  logic [2:0]  err_code;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  assign data = tb_drive ? tb_data : 16'bz;

  sdram_responder dut (
    .clk(clk),
    .rst_n(rst_n),
    .clock_enable(clock_enable),
    .cs_n(cs_n),
    .ras_n(ras_n),
    .cas_n(cas_n),
    .we_n(we_n),
    .addr(addr),
    .bank_addr(bank_addr),
    .data(data),
    .data_mask_low(data_mask_low),
    .data_mask_high(data_mask_high),
    .mode_valid(mode_valid),
    .mode_cl(mode_cl),
    .bank_open(bank_open),
    .ref_cnt(ref_cnt),
    .proto_err(proto_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_differs(input string name, input logic [15:0] act, input logic [15:0] bad);
    checks++;
    if (act === bad) begin
      errors++;
      $display("[TB] FAIL %s: got %h, must not be %h", name, act, bad);
    end
  endtask

  // Present one command at the falling edge, let the rising edge sample it,
  // and return 1 time unit after that edge.
  task automatic apply_stimulus(input tb_cmd_e c, input logic [1:0] b, input logic [12:0] a,
                                input logic drv, input logic [15:0] wd,
                                input logic ml, input logic mh);
    @(negedge clk);
    clock_enable = 1'b1;
    cs_n         = 1'b0;
    case (c)
      C_ACT:   {ras_n, cas_n, we_n} = 3'b011;
      C_RD:    {ras_n, cas_n, we_n} = 3'b101;
      C_WR:    {ras_n, cas_n, we_n} = 3'b100;
      C_PRE:   {ras_n, cas_n, we_n} = 3'b010;
      C_REF:   {ras_n, cas_n, we_n} = 3'b001;
      C_MRS:   {ras_n, cas_n, we_n} = 3'b000;
      default: {ras_n, cas_n, we_n} = 3'b111;
    endcase
    bank_addr      = b;
    addr           = a;
    tb_drive       = drv;
    tb_data        = wd;
    data_mask_low  = ml;
    data_mask_high = mh;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input tb_cmd_e c, input logic [1:0] b, input logic [12:0] a);
    apply_stimulus(c, b, a, 1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {ras_n, cas_n, we_n} = 3'b111;
    tb_drive = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void add_vec(input tb_cmd_e c, input logic [1:0] b, input logic [12:0] a,
                                  input logic drv, input logic [15:0] wd,
                                  input logic ml, input logic mh,
                                  input logic [3:0] bo, input logic pe, input logic [2:0] ec,
                                  input logic [1:0] dm, input logic [15:0] dd);
    vec_t v;
    v.cmd = c; v.bank = b; v.addr = a; v.drive = drv; v.wdata = wd;
    v.mask_low = ml; v.mask_high = mh; v.exp_bank_open = bo;
    v.exp_err = pe; v.exp_code = ec; v.data_mode = dm; v.exp_data = dd;
    vecs.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL global timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Main flow with CL=3 and TRCD=2
    add_vec(C_MRS, 2'd0, 13'h0230, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_ACT, 2'd1, 13'h0005, 0, 16'h0000, 0, 0, 4'h2, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h2, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h2, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_WR,  2'd1, 13'h0403, 1, 16'hA5C3, 0, 0, 4'h0, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_ACT, 2'd1, 13'h0005, 0, 16'h0000, 0, 0, 4'h2, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h2, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_RD,  2'd1, 13'h0403, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd2, 16'hA5C3);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd2, 16'hA5C3);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd1, 16'hA5C3);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd2, 16'hA5C3);
    // byte mask high
    add_vec(C_ACT, 2'd0, 13'h0002, 0, 16'h0000, 0, 0, 4'h1, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h1, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_WR,  2'd0, 13'h0007, 1, 16'h1234, 0, 0, 4'h1, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_WR,  2'd0, 13'h0007, 1, 16'hFFFF, 0, 1, 4'h1, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_RD,  2'd0, 13'h0407, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd2, 16'h12FF);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd2, 16'h12FF);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd1, 16'h12FF);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd2, 16'h12FF);
    // byte mask low and back-to-back reads
    add_vec(C_ACT, 2'd3, 13'h0001, 0, 16'h0000, 0, 0, 4'h8, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h8, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_WR,  2'd3, 13'h0000, 1, 16'h0F0F, 0, 0, 4'h8, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_WR,  2'd3, 13'h0001, 1, 16'hBEEF, 0, 0, 4'h8, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_WR,  2'd3, 13'h0001, 1, 16'h1177, 1, 0, 4'h8, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_RD,  2'd3, 13'h0000, 0, 16'h0000, 0, 0, 4'h8, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_RD,  2'd3, 13'h0401, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd2, 16'h0F0F);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd1, 16'h0F0F);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd1, 16'h11EF);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd2, 16'h11EF);
    // READ to idle bank: flagged one edge later, no data returned
    add_vec(C_ACT, 2'd2, 13'h0000, 0, 16'h0000, 0, 0, 4'h4, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h4, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_WR,  2'd2, 13'h0000, 1, 16'h5A5A, 0, 0, 4'h4, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_PRE, 2'd2, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd0, 16'h0000);
    add_vec(C_RD,  2'd2, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 0, 3'd0, 2'd2, 16'h5A5A);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 1, 3'd2, 2'd2, 16'h5A5A);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 1, 3'd2, 2'd2, 16'h5A5A);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h0, 1, 3'd2, 2'd2, 16'h5A5A);
    // a later violation must not overwrite the first code
    add_vec(C_ACT, 2'd1, 13'h0000, 0, 16'h0000, 0, 0, 4'h2, 1, 3'd2, 2'd0, 16'h0000);
    add_vec(C_ACT, 2'd1, 13'h0000, 0, 16'h0000, 0, 0, 4'h2, 1, 3'd2, 2'd0, 16'h0000);
    add_vec(C_NOP, 2'd0, 13'h0000, 0, 16'h0000, 0, 0, 4'h2, 1, 3'd2, 2'd0, 16'h0000);
    add_vec(C_PRE, 2'd0, 13'h0400, 0, 16'h0000, 0, 0, 4'h0, 1, 3'd2, 2'd0, 16'h0000);

    // T1: reset values
    do_reset();
    #1;
    check_output("reset mode_valid", {15'd0, mode_valid}, 16'd0);
    check_output("reset mode_cl", {13'd0, mode_cl}, 16'd0);
    check_output("reset bank_open", {12'd0, bank_open}, 16'd0);
    check_output("reset ref_cnt", ref_cnt, 16'd0);
    check_output("reset proto_err", {15'd0, proto_err}, 16'd0);
    check_output("reset err_code", {13'd0, err_code}, 16'd0);

    // T1..T4: table
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].cmd, vecs[i].bank, vecs[i].addr, vecs[i].drive,
                     vecs[i].wdata, vecs[i].mask_low, vecs[i].mask_high);
      check_output($sformatf("vec%0d mode_valid", i), {15'd0, mode_valid}, 16'd1);
      check_output($sformatf("vec%0d mode_cl", i), {13'd0, mode_cl}, 16'd3);
      check_output($sformatf("vec%0d bank_open", i), {12'd0, bank_open}, {12'd0, vecs[i].exp_bank_open});
      check_output($sformatf("vec%0d proto_err", i), {15'd0, proto_err}, {15'd0, vecs[i].exp_err});
      check_output($sformatf("vec%0d err_code", i), {13'd0, err_code}, {13'd0, vecs[i].exp_code});
      if (vecs[i].data_mode == 2'd1)
        check_output($sformatf("vec%0d data", i), data, vecs[i].exp_data);
      else if (vecs[i].data_mode == 2'd2)
        check_differs($sformatf("vec%0d data idle", i), data, vecs[i].exp_data);
    end

    // T5: tRCD violation (READ one cycle after ACT)
    do_reset();
    cmd(C_MRS, 2'd0, 13'h0230);
    cmd(C_ACT, 2'd0, 13'h0000);
    cmd(C_RD,  2'd0, 13'h0000);
    check_output("trcd err not yet", {15'd0, proto_err}, 16'd0);
    cmd(C_NOP, 2'd0, 13'h0000);
    check_output("trcd proto_err", {15'd0, proto_err}, 16'd1);
    check_output("trcd err_code", {13'd0, err_code}, 16'd3);
    check_output("trcd bank stays open", {12'd0, bank_open}, 16'h0001);

    // T5: refresh before MRS is legal and counted
    do_reset();
    cmd(C_REF, 2'd0, 13'h0000);
    cmd(C_REF, 2'd0, 13'h0000);
    cmd(C_REF, 2'd0, 13'h0000);
    cmd(C_NOP, 2'd0, 13'h0000);
    check_output("ref_cnt 3", ref_cnt, 16'd3);
    check_output("ref idle no err", {15'd0, proto_err}, 16'd0);
    // ACT before MRS
    cmd(C_ACT, 2'd1, 13'h0000);
    cmd(C_NOP, 2'd0, 13'h0000);
    check_output("act before mrs code", {13'd0, err_code}, 16'd4);
    check_output("act before mrs bank", {12'd0, bank_open}, 16'd0);

    // bad MRS (CL field 101) leaves the mode unchanged
    do_reset();
    cmd(C_MRS, 2'd0, 13'h0250);
    cmd(C_NOP, 2'd0, 13'h0000);
    check_output("bad mrs code", {13'd0, err_code}, 16'd6);
    check_output("bad mrs mode_valid", {15'd0, mode_valid}, 16'd0);

    // CL=2 read timing, then REF with an open bank
    do_reset();
    cmd(C_MRS, 2'd0, 13'h0220);
    check_output("cl2 mode_cl", {13'd0, mode_cl}, 16'd2);
    cmd(C_ACT, 2'd0, 13'h0003);
    cmd(C_NOP, 2'd0, 13'h0000);
    apply_stimulus(C_WR, 2'd0, 13'h0002, 1'b1, 16'h7E81, 1'b0, 1'b0);
    cmd(C_RD, 2'd0, 13'h0002);
    check_differs("cl2 data early", data, 16'h7E81);
    cmd(C_NOP, 2'd0, 13'h0000);
    check_output("cl2 data", data, 16'h7E81);
    cmd(C_NOP, 2'd0, 13'h0000);
    check_differs("cl2 data late", data, 16'h7E81);
    cmd(C_REF, 2'd0, 13'h0000);
    cmd(C_NOP, 2'd0, 13'h0000);
    check_output("ref open bank code", {13'd0, err_code}, 16'd5);
    check_output("ref open bank cnt", ref_cnt, 16'd0);

    // T5: refresh watchdog; REF restarts it, timeout at REF_MAX+1 edges
    do_reset();
    cmd(C_MRS, 2'd0, 13'h0230);
    for (int k = 0; k < 999; k++) cmd(C_NOP, 2'd0, 13'h0000);
    check_output("wd before ref", {15'd0, proto_err}, 16'd0);
    cmd(C_REF, 2'd0, 13'h0000);
    for (int k = 0; k < 1025; k++) cmd(C_NOP, 2'd0, 13'h0000);
    check_output("wd at limit", {15'd0, proto_err}, 16'd0);
    cmd(C_NOP, 2'd0, 13'h0000);
    check_output("wd proto_err", {15'd0, proto_err}, 16'd1);
    check_output("wd err_code", {13'd0, err_code}, 16'd7);
    check_output("wd ref_cnt", ref_cnt, 16'd1);

    // T6: reset asserted during the read-data cycle
    do_reset();
    cmd(C_MRS, 2'd0, 13'h0230);
    cmd(C_ACT, 2'd0, 13'h0000);
    cmd(C_NOP, 2'd0, 13'h0000);
    apply_stimulus(C_WR, 2'd0, 13'h0000, 1'b1, 16'hC33C, 1'b0, 1'b0);
    cmd(C_RD,  2'd0, 13'h0000);
    cmd(C_NOP, 2'd0, 13'h0000);
    cmd(C_NOP, 2'd0, 13'h0000);
    check_output("pre-reset data", data, 16'hC33C);
    #2;
    rst_n = 1'b0;
    #1;
    check_differs("async reset data", data, 16'hC33C);
    check_output("async reset mode_valid", {15'd0, mode_valid}, 16'd0);
    check_output("async reset mode_cl", {13'd0, mode_cl}, 16'd0);
    check_output("async reset bank_open", {12'd0, bank_open}, 16'd0);
    check_output("async reset ref_cnt", ref_cnt, 16'd0);
    check_output("async reset proto_err", {15'd0, proto_err}, 16'd0);
    @(negedge clk);
    {ras_n, cas_n, we_n} = 3'b111;
    rst_n = 1'b1;
    cmd(C_NOP, 2'd0, 13'h0000);
    check_differs("after reset no drive", data, 16'hC33C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
